// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared types and helpers for the load/store unit.
// Revision : 1.0
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Byte-lane mask for an access of the given size, before lane shifting.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] m;
        case (size_e'(size))
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Brief    : Combinational store lane shift/mask and load shift/extend.
// Revision : 1.0
// ============================================================================
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    input  logic [2:0]      offset,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [7:0]      wmask,
    output logic [XLEN-1:0] wdata_sh,
    output logic [XLEN-1:0] rdata_ext
);

    logic [5:0]      bit_shift;
    logic [XLEN-1:0] rdata_sh;

    assign bit_shift = {offset, 3'b000};
    assign wmask     = size_mask(size) << offset;
    assign wdata_sh  = wdata << bit_shift;
    assign rdata_sh  = rdata >> bit_shift;

    // Doubleword loads have nothing to extend, so they pass through unchanged.
    always_comb begin
        rdata_ext = rdata_sh;
        case (size_e'(size))
            SZ_B: rdata_ext = {{(XLEN-8){rdata_sh[7] & ~is_unsigned}},   rdata_sh[7:0]};
            SZ_H: rdata_ext = {{(XLEN-16){rdata_sh[15] & ~is_unsigned}}, rdata_sh[15:0]};
            SZ_W: rdata_ext = {{(XLEN-32){rdata_sh[31] & ~is_unsigned}}, rdata_sh[31:0]};
            default: rdata_ext = rdata_sh;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Brief    : Three-state load/store unit driving a single-cycle memory bus.
//            Optional feature macro: LSU_MISALIGN_TRAP_EN.
// Revision : 1.0
// ============================================================================
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int NREG_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_store,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic [XLEN-1:0]   in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [NREG_W-1:0] in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_rdata,
    output logic [NREG_W-1:0] out_rd,
    output logic              out_misalign,
    output logic [XLEN-1:0]   mem_raddr,
    output logic              mem_read,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic [XLEN-1:0]   mem_waddr,
    output logic              mem_write,
    output logic [7:0]        mem_wmask,
    output logic [XLEN-1:0]   mem_wdata
);

    state_e            state;
    logic              op_store;
    logic [1:0]        op_size;
    logic              op_unsigned;
    logic [XLEN-1:0]   op_addr;
    logic [XLEN-1:0]   op_wdata;
    logic              misalign_q;

    logic [3:0]        lo_mask;
    logic [XLEN-1:0]   addr_use;
    logic              trap;
    logic [7:0]        wmask_sh;
    logic [XLEN-1:0]   wdata_sh;
    logic [XLEN-1:0]   rdata_ext;
    logic              in_access;

    assign lo_mask = size_bytes(in_size) - 4'd1;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap     = |({1'b0, in_addr[2:0]} & lo_mask);
    assign addr_use = in_addr;
`else
    // Without trapping, misaligned ops are silently rounded down to their natural alignment.
    assign trap     = 1'b0;
    assign addr_use = in_addr & ~{{(XLEN-4){1'b0}}, lo_mask};
`endif

    lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .size        (op_size),
        .is_unsigned (op_unsigned),
        .offset      (op_addr[2:0]),
        .wdata       (op_wdata),
        .rdata       (mem_rdata),
        .wmask       (wmask_sh),
        .wdata_sh    (wdata_sh),
        .rdata_ext   (rdata_ext)
    );

    // Bus strobes come straight from the state register so a reset kills them at once.
    assign in_access    = (state == ACCESS);
    assign in_ready     = (state == IDLE);
    assign mem_read     = in_access & ~op_store;
    assign mem_write    = in_access & op_store;
    assign mem_wmask    = mem_write ? wmask_sh : 8'h00;
    assign mem_wdata    = wdata_sh;
    assign mem_raddr    = {op_addr[XLEN-1:3], 3'b000};
    assign mem_waddr    = {op_addr[XLEN-1:3], 3'b000};
    assign out_misalign = misalign_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op_store    <= 1'b0;
            op_size     <= 2'd0;
            op_unsigned <= 1'b0;
            op_addr     <= '0;
            op_wdata    <= '0;
            out_valid   <= 1'b0;
            out_rdata   <= '0;
            out_rd      <= '0;
            misalign_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_store    <= in_store;
                        op_size     <= in_size;
                        op_unsigned <= in_unsigned;
                        op_addr     <= addr_use;
                        op_wdata    <= in_wdata;
                        out_rd      <= in_rd;
                        misalign_q  <= trap;
                        if (trap) begin
                            state     <= RESP;
                            out_valid <= 1'b1;
                            out_rdata <= '0;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    state     <= RESP;
                    out_valid <= 1'b1;
                    out_rdata <= op_store ? '0 : rdata_ext;
                end
                RESP: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit sitting directly upstream of the DPI memory blackbox.
- Accepts one memory op from EX via valid/ready.
- Drives a single-cycle, 8-byte-aligned read or write strobe (mem_* bus), byte-lane shifting store data and mask.
- Registers and extracts/extends load data, presenting the result to WB via valid/ready.

Parameters:
- XLEN, 64, data/address width (only 64 is supported)
- NREG_W, 5, destination register index width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  EX presents an op
- in_ready  out  1  LSU can accept
- in_store  in  1  1 = store, 0 = load
- in_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword
- in_unsigned  in  1  zero-extend load (ignored for stores)
- in_addr  in  64  byte address
- in_wdata  in  64  store data, LSB-justified
- in_rd  in  5  destination register tag
- out_valid  out  1  result available
- out_ready  in  1  WB consumes
- out_rdata  out  64  extended load data (0 for stores)
- out_rd  out  5  tag passthrough
- out_misalign  out  1  misaligned-access flag
- mem_raddr  out  64  aligned read address
- mem_read  out  1  read strobe
- mem_rdata  in  64  read data, combinational in the same cycle as mem_read
- mem_waddr  out  64  aligned write address
- mem_write  out  1  write strobe
- mem_wmask  out  8  byte-lane write mask
- mem_wdata  out  64  lane-shifted write data

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - in_ready = 1.
  - On in_valid, latch store/size/unsigned/addr/wdata/rd, then go to ACCESS.
  - With the trap feature on and the address misaligned, go straight to RESP instead.
- ACCESS:
  - Exactly one cycle; in_ready = 0.
  - mem_raddr = mem_waddr = {addr[63:3], 3'b0}.
  - Load: mem_read = 1; capture mem_rdata into a register at the clock edge.
  - Store: mem_write = 1; mem_wmask = size_mask << addr[2:0], where size_mask is 0x01/0x03/0x0F/0xFF; mem_wdata = wdata << (8*addr[2:0]).
  - Next state is RESP.
- RESP:
  - out_valid = 1; out_rdata, out_rd and out_misalign are held stable.
  - Return to IDLE on out_ready; stay in RESP otherwise (backpressure).
- Load extract:
  - Shift the captured data right by 8*addr[2:0].
  - Truncate to the op size.
  - Sign-extend from the MSB of that size unless in_unsigned or size = 3.
- Store result: out_rdata = 0, out_valid still asserted so WB/commit observes completion.
- Strobes and bus:
  - mem_read and mem_write are never both 1.
  - Both are 0 outside ACCESS; mem_wmask = 0 outside ACCESS.
  - Strobes, mask and addresses are decoded combinationally from the state register.
- Latency and throughput:
  - Op accepted at edge N; ACCESS during cycle N+1; out_valid from cycle N+2.
  - Minimum one op per 3 cycles.
  - No acceptance in RESP, even if out_ready is high.
- Reset:
  - state = IDLE.
  - out_valid = 0, out_rdata = 0, out_rd = 0, out_misalign = 0.
  - All strobes 0; in_ready = 1 after release.
- Reset mid-op: assertion during ACCESS drops the strobes immediately, because they are decoded from the state. The op is discarded and no result is produced.
- Misalignment is defined as addr[2:0] & (size_bytes-1) != 0. Size 0 is never misaligned.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned op skips ACCESS, so no memory strobe is issued.
  - RESP presents out_misalign = 1 and out_rdata = 0.
- Undefined:
  - The address low bits are forced aligned (addr & ~(size_bytes-1)) before use.
  - The access proceeds normally; out_misalign is tied 0.

Decomposition:
- Package lsu_pkg:
  - size enum (SZ_B/SZ_H/SZ_W/SZ_D).
  - state enum (IDLE/ACCESS/RESP).
  - Functions size_mask(size) and size_bytes(size).
- Sub-module lsu_align: purely combinational.
  - Store lane shift and mask generation.
  - Load shift and extend.
- The lsu top holds the FSM and the registers.

Test Plan:
- Load byte, signed: addr = 0x80000005, mem_rdata = 0x0000_8000_0000_0000 -> mem_raddr = 0x80000000, mem_read = 1 for one cycle, out_rdata = 0xFFFF_FFFF_FFFF_FF80 at cycle N+2.
- Load half, unsigned: addr = 0x80000006, mem_rdata = 0xBEEF_0000_0000_0000 -> out_rdata = 0x0000_0000_0000_BEEF.
- Store word: addr = 0x80000004, wdata = 0x1122_3344 -> mem_waddr = 0x80000000, mem_wmask = 0xF0, mem_wdata = 0x1122_3344_0000_0000, out_valid with out_rdata = 0.
- Backpressure: hold out_ready = 0 for 5 cycles -> out_valid and out_rdata stable, in_ready = 0, no further strobes. Raise out_ready -> IDLE and in_ready = 1 the next cycle.
- Misaligned dword load at 0x80000003:
  - With LSU_MISALIGN_TRAP_EN: no mem_read, out_misalign = 1 at N+1.
  - Without it: mem_raddr = 0x80000000, out_misalign = 0.
- Reset asserted during a store's ACCESS cycle -> mem_write falls in the same cycle, out_valid stays 0, and the next accepted op completes normally.
